conv_acc_dispatcher: RTL and testbench
======================================

Name: conv_acc_dispatcher

Overview:
- Parametrised successor to the single-mode EPU accelerator top: accepts layer commands (one-hot unit mode + w8 word) into a small command queue and launches them back-to-back on NUM_UNITS compute units (conv, maxpool, fc, ...).
- Owns the bus-switcher select, the per-unit start pulses, finish collection, a run watchdog and sticky error reporting.
- Sits between the EPU CSR/DMA front end and the compute units plus bus switcher.

Parameters:
- NUM_UNITS, 3, number of compute units; width of mode/start/finish/sel vectors.
- QDEPTH, 4, command queue depth (power of 2, >=2).
- W8_W, 32, width of the per-command w8 word.
- TO_W, 16, watchdog counter width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  queue not full
- cmd_mode  in  NUM_UNITS  one-hot target unit
- cmd_w8  in  W8_W  per-layer word forwarded to the unit
- unit_start  out  NUM_UNITS  one-cycle start pulse to the selected unit
- unit_finish  in  NUM_UNITS  finish from each unit (level or pulse)
- unit_sel  out  NUM_UNITS  one-hot bus-switcher select; all-zero means idle
- unit_w8  out  W8_W  w8 of the running command
- timeout_limit  in  TO_W  watchdog limit in cycles; 0 disables it
- clr_err  in  1  clears err/err_code
- busy  out  1  FSM not IDLE or queue non-empty
- done  out  1  one-cycle pulse per completed command
- done_mode  out  NUM_UNITS  mode of the completed command, valid with done
- err  out  1  sticky error
- err_code  out  2  0 none, 1 illegal mode, 2 timeout, 3 spurious finish; first error wins

Behaviour:
- Reset (async assert, sync release): queue empty, FSM IDLE. All outputs 0, except cmd_ready = 1.
- Queue
  - Push on cmd_valid & cmd_ready.
  - cmd_ready = !full; simultaneous push and pop are allowed when full.
  - Pointers wrap modulo QDEPTH; count width is log2(QDEPTH)+1.
- Illegal mode: cmd_mode with popcount != 1 is accepted (handshake completes), not stored, and sets err/code 1 on the next edge.
- FSM IDLE -> LAUNCH -> RUN -> DONE -> IDLE.
  - IDLE: if queue non-empty, pop the head, latch mode and w8, go to LAUNCH.
  - LAUNCH: unit_start = latched mode for exactly 1 cycle; go to RUN.
  - RUN: wait for unit_finish & mode != 0, then go to DONE.
  - DONE: done = 1, done_mode = mode; go to IDLE.
- unit_sel and unit_w8 are held at the latched values from LAUNCH through DONE; 0 in IDLE.
- Latency
  - Command pushed at edge k into an empty, idle dispatcher: unit_start is high in cycle k+2.
  - Finish sampled at edge f: done is high in cycle f+1.
  - Back-to-back commands: next unit_start occurs 3 cycles after the previous done.
- unit_finish is ignored in LAUNCH (the previous unit may still hold a level finish). Only RUN samples it.
- Spurious finish: a unit_finish bit outside the selected unit, seen while in RUN, sets err/code 3 and is otherwise ignored. Finishes while IDLE are ignored with no error.
- Watchdog
  - Counter clears on LAUNCH and increments each RUN cycle.
  - If timeout_limit != 0 and the counter reaches timeout_limit without finish: err/code 2, FSM returns to IDLE with no done pulse, and the queue continues with the next command.
  - Finish in the same cycle the count reaches the limit: finish wins.
- Error capture
  - err/err_code capture the first error only; later errors do not overwrite it.
  - clr_err clears both on the next edge.
  - clr_err coincident with a new error: the new error is captured.
- Counters saturate; no overflow wrap on the watchdog counter.
- Reset mid-run: everything is cleared immediately (async). Queued commands are lost.

Test Plan:
- Single conv command: mode=3'b001, w8=0xA5A5_0001 pushed at cycle 0; unit_finish[0] at cycle 10 -> unit_start=001 in cycle 2 only, unit_sel=001 in cycles 2-11, done=1 in cycle 11 with done_mode=001, busy=0 in cycle 12.
- Queue fill: push 5 commands back-to-back with QDEPTH=4 and units never finishing -> after the FSM pops the first, cmd_ready=1 until 4 are stored, then 0. The 5th is held until the first completes, and all complete in order with matching done_mode/unit_w8.
- Illegal mode: cmd_mode=3'b011, then 3'b000 -> both accepted, no unit_start, err=1/code=1; clr_err -> err=0. A subsequent legal command runs normally.
- Timeout: timeout_limit=8, no finish -> err/code=2 after 8 RUN cycles, no done, unit_sel returns to 0, the next queued command launches.
- Spurious finish: running unit 1 (sel=010), pulse unit_finish[2] -> err/code=3, still RUN; unit_finish[1] then produces done=1, done_mode=010.
- Reset mid-RUN with 2 queued commands: assert rst asynchronously mid-cycle -> all outputs 0 immediately, cmd_ready=1; after release, no start pulses occur.

Source files
------------

// File: rtl/conv_acc_dispatcher.sv
// conv_acc_dispatcher
//
// Purpose:
//   Takes layer commands (a one-hot unit mode plus a w8 word) into a small
//   command queue. It launches them one at a time on NUM_UNITS compute units.
//   It drives the bus-switcher select and the per-unit start pulses, and it
//   collects the unit finish signals. A run watchdog and a sticky error
//   register cover units that hang or misbehave.
//
// Handshake:
//   A command transfers on any rising clk edge where cmd_valid and cmd_ready
//   are both high. cmd_ready depends only on the queue fill level, never on
//   cmd_valid. A command whose mode does not have exactly one bit set still
//   completes the handshake. It is dropped and raises error code 1.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   cmd_valid/ready command handshake; cmd_ready = queue not full
//   cmd_mode        one-hot target unit of the offered command
//   cmd_w8          per-layer word forwarded to the unit
//   unit_start      one-cycle start pulse to the selected unit
//   unit_finish     finish from each unit (level or pulse)
//   unit_sel        one-hot bus-switcher select, all-zero when idle
//   unit_w8         w8 of the running command, zero when idle
//   timeout_limit   watchdog limit in RUN cycles; 0 disables the watchdog
//   clr_err         clears err/err_code on the next edge
//   busy            FSM not idle or queue not empty
//   done/done_mode  one-cycle completion pulse and the completed mode
//   err/err_code    sticky first error: 1 illegal mode, 2 timeout,
//                   3 spurious finish
//   state_dbg       current FSM state, for debug visibility
//
// Timing:
//   All unit-facing outputs are registered one edge after the FSM decides.
//   So unit_start and unit_sel rise in the first RUN cycle. They are not
//   raised in the LAUNCH cycle.

module conv_acc_dispatcher #(
   parameter int NUM_UNITS = 3,
   parameter int QDEPTH    = 4,
   parameter int W8_W      = 32,
   parameter int TO_W      = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [NUM_UNITS-1:0] cmd_mode,
   input  logic [W8_W-1:0]      cmd_w8,
   output logic [NUM_UNITS-1:0] unit_start,
   input  logic [NUM_UNITS-1:0] unit_finish,
   output logic [NUM_UNITS-1:0] unit_sel,
   output logic [W8_W-1:0]      unit_w8,
   input  logic [TO_W-1:0]      timeout_limit,
   input  logic                 clr_err,
   output logic                 busy,
   output logic                 done,
   output logic [NUM_UNITS-1:0] done_mode,
   output logic                 err,
   output logic [1:0]           err_code,
   output logic [1:0]           state_dbg
);

   localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LAUNCH = 2'd1,
      S_RUN    = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t state;

   // Command queue storage. The data needs no reset because the count
   // guards every read.
   logic [NUM_UNITS-1:0] q_mode [QDEPTH];
   logic [W8_W-1:0]      q_w8   [QDEPTH];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [CNT_W-1:0]     count;

   logic full;
   logic empty;
   logic handshake;
   logic mode_legal;
   logic push;
   logic pop;

   // Latched command and watchdog.
   logic [NUM_UNITS-1:0] mode_r;
   logic [W8_W-1:0]      w8_r;
   logic [TO_W-1:0]      wd_cnt;
   logic [TO_W-1:0]      wd_next;

   logic finish_hit;
   logic spurious;
   logic timeout_hit;
   logic [1:0] new_code;

   assign full       = (count == CNT_W'(QDEPTH));
   assign empty      = (count == '0);
   assign cmd_ready  = !full;
   assign handshake  = cmd_valid && cmd_ready;
   assign mode_legal = ($countones(cmd_mode) == 1);
   assign push       = handshake && mode_legal;
   assign pop        = (state == S_IDLE) && !empty;
   assign busy       = (state != S_IDLE) || !empty;
   assign state_dbg  = state;

   // The watchdog saturates instead of wrapping.
   assign wd_next = (wd_cnt == '1) ? wd_cnt : wd_cnt + TO_W'(1);

   // Only RUN looks at the finish lines. In LAUNCH, the previous unit may
   // still be holding a level finish.
   assign finish_hit  = (state == S_RUN) && ((unit_finish & mode_r) != '0);
   assign spurious    = (state == S_RUN) && ((unit_finish & ~mode_r) != '0);
   // A finish on the same edge as the limit takes priority.
   assign timeout_hit = (state == S_RUN) && !finish_hit &&
                        (timeout_limit != '0) && (wd_next >= timeout_limit);

   always_comb begin
      new_code = 2'd0;
      if (handshake && !mode_legal) begin
         new_code = 2'd1;
      end else if (timeout_hit) begin
         new_code = 2'd2;
      end else if (spurious) begin
         new_code = 2'd3;
      end
   end

   // ---------------- queue ----------------
   always_ff @(posedge clk) begin
      if (push) begin
         q_mode[wr_ptr] <= cmd_mode;
         q_w8[wr_ptr]   <= cmd_w8;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // ---------------- FSM with registered outputs ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         mode_r     <= '0;
         w8_r       <= '0;
         wd_cnt     <= '0;
         unit_start <= '0;
         unit_sel   <= '0;
         unit_w8    <= '0;
         done       <= 1'b0;
         done_mode  <= '0;
      end else begin
         unit_start <= '0;
         done       <= 1'b0;
         done_mode  <= '0;
         case (state)
            S_IDLE: begin
               if (!empty) begin
                  mode_r <= q_mode[rd_ptr];
                  w8_r   <= q_w8[rd_ptr];
                  state  <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               unit_start <= mode_r;
               unit_sel   <= mode_r;
               unit_w8    <= w8_r;
               wd_cnt     <= '0;
               state      <= S_RUN;
            end
            S_RUN: begin
               if (finish_hit) begin
                  done      <= 1'b1;
                  done_mode <= mode_r;
                  state     <= S_DONE;
               end else if (timeout_hit) begin
                  // A timed-out command is abandoned without a done pulse.
                  unit_sel <= '0;
                  unit_w8  <= '0;
                  state    <= S_IDLE;
               end else begin
                  wd_cnt <= wd_next;
               end
            end
            S_DONE: begin
               unit_sel <= '0;
               unit_w8  <= '0;
               state    <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // ---------------- sticky error ----------------
   // Once set, the error holds until clr_err. If an error arrives together
   // with clr_err, the new error is kept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err      <= 1'b0;
         err_code <= 2'd0;
      end else if (clr_err || !err) begin
         err      <= (new_code != 2'd0);
         err_code <= new_code;
      end
   end

endmodule

// File: tb/tb_conv_acc_dispatcher.sv
// Testbench for conv_acc_dispatcher.
//
// The reference model is an ordered list of legal commands, in the order
// they were accepted. Every unit_start must launch the oldest accepted
// command that has not run yet. Every done must report the mode of the
// command that is running.

module tb_conv_acc_dispatcher;

   localparam int NU = 3;
   localparam int WW = 32;
   localparam int TW = 16;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT ----------------
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [NU-1:0] cmd_mode = '0;
   logic [WW-1:0] cmd_w8 = '0;
   logic [NU-1:0] unit_start;
   logic [NU-1:0] unit_finish;
   logic [NU-1:0] unit_sel;
   logic [WW-1:0] unit_w8;
   logic [TW-1:0] timeout_limit = '0;
   logic          clr_err = 1'b0;
   logic          busy;
   logic          done;
   logic [NU-1:0] done_mode;
   logic          err;
   logic [1:0]    err_code;
   logic [1:0]    state_dbg;

   logic [NU-1:0] man_finish = '0;
   logic [NU-1:0] resp_finish = '0;
   assign unit_finish = man_finish | resp_finish;

   conv_acc_dispatcher #(.NUM_UNITS(NU), .QDEPTH(4), .W8_W(WW), .TO_W(TW)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_mode(cmd_mode), .cmd_w8(cmd_w8),
      .unit_start(unit_start), .unit_finish(unit_finish),
      .unit_sel(unit_sel), .unit_w8(unit_w8),
      .timeout_limit(timeout_limit), .clr_err(clr_err),
      .busy(busy), .done(done), .done_mode(done_mode),
      .err(err), .err_code(err_code), .state_dbg(state_dbg)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;
   logic [NU+WW-1:0] exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops the model at every launch and checks the completions.
   logic [NU+WW-1:0] cur;
   logic [NU-1:0]    cur_mode = '0;
   int  done_cnt    = 0;
   int  last_done   = 0;
   bit  b2b_pending = 0;

   always @(negedge clk) begin
      if (rst) begin
         b2b_pending = 0;
         cur_mode    = '0;
      end else begin
         if (unit_start != '0) begin
            if (exp_q.size() == 0) begin
               check("start_unexpected", 64'(unit_start), 64'd0);
            end else begin
               cur      = exp_q.pop_front();
               cur_mode = cur[NU+WW-1:WW];
               check("start_mode", 64'(unit_start), 64'(cur_mode));
               check("start_sel", 64'(unit_sel), 64'(cur_mode));
               check("start_w8", 64'(unit_w8), 64'(cur[WW-1:0]));
               if (b2b_pending) check("b2b_gap", 64'(cyc - last_done), 64'd3);
            end
            b2b_pending = 0;
         end
         if (done) begin
            check("done_mode", 64'(done_mode), 64'(cur_mode));
            done_cnt++;
            last_done   = cyc;
            b2b_pending = (exp_q.size() != 0);
         end
      end
   end

   // Auto-responding unit: finishes the started unit after a random delay.
   bit            auto_resp = 0;
   logic [NU-1:0] resp_bits;
   int            resp_d;
   always begin
      @(negedge clk);
      if (auto_resp && !rst && unit_start != '0) begin
         resp_bits = unit_start;
         resp_d    = $urandom_range(0, 5);
         @(posedge clk); #1;
         repeat (resp_d) begin @(posedge clk); #1; end
         resp_finish = resp_bits;
         @(posedge clk); #1;
         resp_finish = '0;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "global timeout");
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic push_cmd(input logic [NU-1:0] m, input logic [WW-1:0] w, output int waited);
      int n = 0;
      cmd_valid = 1'b1; cmd_mode = m; cmd_w8 = w;
      while (!cmd_ready && n < 300) begin tick(); n++; end
      waited = n;
      if (!cmd_ready) begin
         check("push_ready", 64'(cmd_ready), 64'd1);
      end else begin
         @(posedge clk);
         if ($countones(m) == 1) exp_q.push_back({m, w});
         #1;
      end
      cmd_valid = 1'b0;
   endtask

   task automatic wait_start();
      int n = 0;
      @(negedge clk);
      while (unit_start == '0 && n < 60) begin @(negedge clk); n++; end
      check("start_seen", 64'(unit_start != '0), 64'd1);
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while ((busy || exp_q.size() != 0 || unit_finish != '0) && n < 800) begin
         @(negedge clk); n++;
      end
      check("drain_busy", 64'(busy), 64'd0);
      check("drain_model", 64'(exp_q.size()), 64'd0);
      tick();
   endtask

   task automatic clear_err();
      clr_err = 1'b1; tick(); clr_err = 1'b0;
      check("clr_err", 64'({err, err_code}), 64'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int w;
      int legal_cnt;
      int done_base;
      bit any_ill;
      logic [NU-1:0] m;
      logic [NU-1:0] ill [5];
      ill = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};

      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_start", 64'(unit_start), 64'd0);
      check("rst_sel", 64'(unit_sel), 64'd0);
      check("rst_busy_done", 64'({busy, done, err, err_code}), 64'd0);
      check("rst_ready", 64'(cmd_ready), 64'd1);
      rst = 1'b0;
      tick();

      // Single conv command with exact cycle timing.
      push_cmd(3'b001, 32'hA5A5_0001, w);
      for (int c = 0; c <= 12; c++) begin
         man_finish = (c == 10) ? 3'b001 : 3'b000;
         @(negedge clk);
         check($sformatf("t1_start_c%0d", c), 64'(unit_start), (c == 2) ? 64'd1 : 64'd0);
         check($sformatf("t1_sel_c%0d", c), 64'(unit_sel), (c >= 2 && c <= 11) ? 64'd1 : 64'd0);
         check($sformatf("t1_done_c%0d", c), 64'(done), (c == 11) ? 64'd1 : 64'd0);
         check($sformatf("t1_busy_c%0d", c), 64'(busy), (c < 12) ? 64'd1 : 64'd0);
         tick();
      end
      man_finish = '0;

      // Queue fill: one command runs and four are queued. The sixth must wait.
      push_cmd(3'b001, 32'h1111_0001, w);
      push_cmd(3'b010, 32'h1111_0002, w);
      push_cmd(3'b100, 32'h1111_0003, w);
      push_cmd(3'b001, 32'h1111_0004, w);
      push_cmd(3'b010, 32'h1111_0005, w);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("fill_ready_low", 64'(cmd_ready), 64'd0);
      end
      tick();
      auto_resp  = 1;
      man_finish = unit_sel;
      tick();
      man_finish = '0;
      push_cmd(3'b100, 32'h1111_0006, w);
      check("fill_sixth_held", 64'(w > 0), 64'd1);
      wait_idle();

      // Illegal modes.
      auto_resp = 0;
      push_cmd(3'b011, 32'h2222_0001, w);
      check("ill_err", 64'({err, err_code}), 64'({1'b1, 2'd1}));
      push_cmd(3'b000, 32'h2222_0002, w);
      check("ill_err2", 64'({err, err_code}), 64'({1'b1, 2'd1}));
      check("ill_not_busy", 64'(busy), 64'd0);
      clear_err();
      auto_resp = 1;
      push_cmd(3'b100, 32'h2222_0003, w);
      wait_idle();

      // Timeout: A never finishes, and B launches afterwards.
      auto_resp = 0;
      timeout_limit = 16'd8;
      push_cmd(3'b010, 32'h3333_000A, w);
      push_cmd(3'b100, 32'h3333_000B, w);
      wait_start();
      for (int i = 0; i <= 8; i++) begin
         if (i > 0) @(negedge clk);
         check($sformatf("to_done_%0d", i), 64'(done), 64'd0);
         if (i < 8) begin
            check($sformatf("to_noerr_%0d", i), 64'(err), 64'd0);
            check($sformatf("to_sel_%0d", i), 64'(unit_sel), 64'b010);
         end else begin
            check("to_err", 64'({err, err_code}), 64'({1'b1, 2'd2}));
            check("to_sel_idle", 64'(unit_sel), 64'd0);
         end
      end
      auto_resp = 1;
      wait_idle();

      // A finish on the same edge as the watchdog limit wins.
      auto_resp = 0;
      clear_err();
      push_cmd(3'b001, 32'h4444_0001, w);
      wait_start();
      repeat (7) tick();
      man_finish = 3'b001;
      tick();
      man_finish = '0;
      @(negedge clk);
      check("fw_done", 64'(done), 64'd1);
      check("fw_noerr", 64'(err), 64'd0);
      timeout_limit = '0;
      wait_idle();

      // Spurious finish.
      push_cmd(3'b010, 32'h5555_0001, w);
      wait_start();
      tick(); man_finish = 3'b100;
      tick(); man_finish = '0;
      @(negedge clk);
      check("sp_err", 64'({err, err_code}), 64'({1'b1, 2'd3}));
      check("sp_still_run", 64'({busy, unit_sel, done}), 64'({1'b1, 3'b010, 1'b0}));
      tick(); man_finish = 3'b010;
      tick(); man_finish = '0;
      @(negedge clk);
      check("sp_done", 64'({done, done_mode}), 64'({1'b1, 3'b010}));
      tick();
      // The first error wins, and a new error coincident with clr_err is kept.
      push_cmd(3'b111, 32'h5555_0002, w);
      check("first_wins", 64'(err_code), 64'd3);
      clr_err = 1'b1;
      push_cmd(3'b000, 32'h5555_0003, w);
      clr_err = 1'b0;
      check("clr_vs_new", 64'({err, err_code}), 64'({1'b1, 2'd1}));
      clear_err();

      // Reset in the middle of RUN, with two commands queued.
      push_cmd(3'b001, 32'h6666_0001, w);
      push_cmd(3'b010, 32'h6666_0002, w);
      push_cmd(3'b100, 32'h6666_0003, w);
      wait_start();
      #2 rst = 1'b1;
      #1;
      check("mr_start_sel", 64'({unit_start, unit_sel}), 64'd0);
      check("mr_w8", 64'(unit_w8), 64'd0);
      check("mr_flags", 64'({busy, done, done_mode, err, err_code}), 64'd0);
      check("mr_ready", 64'(cmd_ready), 64'd1);
      exp_q.delete();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check("mr_idle_after", 64'({busy, unit_sel}), 64'd0);
      tick();

      // Randomized traffic; the watchdog is off and the unit responses are random.
      auto_resp = 1;
      legal_cnt = 0;
      any_ill   = 0;
      done_base = done_cnt;
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 99) < 85) begin
            m = 3'b001 << $urandom_range(0, 2);
            legal_cnt++;
         end else begin
            m = ill[$urandom_range(0, 4)];
            any_ill = 1;
         end
         push_cmd(m, $urandom, w);
         repeat ($urandom_range(0, 3)) tick();
      end
      wait_idle();
      check("rnd_done_count", 64'(done_cnt - done_base), 64'(legal_cnt));
      check("rnd_err", 64'({err, err_code}), any_ill ? 64'({1'b1, 2'd1}) : 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
